// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types and constants for the rng sequencing controller
package rng_pkg;

    localparam int RNG_WIDTH = 64;

    typedef logic [7:0] rng_warmup_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } rng_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a rotating pointer
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [PTR_W-1:0] next_ptr
);

    // Scan from ptr upward with wrap; the first pending request wins and the pointer moves past it
    always_comb begin
        logic found;
        winner   = '0;
        next_ptr = ptr;
        found    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N_REQ;
            if (en && !found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                next_ptr    = PTR_W'((idx + 1) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - seed/warm-up sequencer and round-robin number sharing for the rng core (optional RNG_ARB_STATS_EN)
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = RNG_WIDTH,
    parameter int WARMUP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_req_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic             seed_ack_o,
    output logic             ready_o,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [WIDTH-1:0] number_o,
    output logic             rng_loadseed_o,
    output logic [WIDTH-1:0] rng_seed_o,
`ifdef RNG_ARB_STATS_EN
    output logic [31:0]      grant_cnt_o,
`endif
    input  logic [WIDTH-1:0] rng_number_i
);

    localparam int PTR_W = $clog2(N_REQ);
    // Counter is loaded on leaving LOAD and RUN is entered the edge after it reads zero
    localparam rng_warmup_t WARM_INIT = rng_warmup_t'((WARMUP > 0) ? WARMUP - 1 : 0);

    rng_state_t       state_q, state_d;
    rng_warmup_t      warm_cnt_q;
    logic [PTR_W-1:0] ptr_q;
    logic [WIDTH-1:0] seed_q;
    logic [N_REQ-1:0] gnt_q;
    logic [WIDTH-1:0] number_q;
    logic             arb_en;
    logic [N_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0] arb_next_ptr;

    // A seed request preempts everything, including a grant in the same cycle
    assign arb_en = (state_q == ST_RUN) && !seed_req_i;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req      (req_i),
        .en       (arb_en),
        .ptr      (ptr_q),
        .winner   (arb_gnt),
        .next_ptr (arb_next_ptr)
    );

    // Next-state decode for the seed / warm-up / run sequence
    always_comb begin
        state_d = state_q;
        if (seed_req_i) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD:   state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                ST_WARMUP: if (warm_cnt_q == '0) state_d = ST_RUN;
                default:   state_d = state_q;
            endcase
        end
    end

    // State register, warm-up countdown and captured seed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            warm_cnt_q <= '0;
            seed_q     <= '0;
        end else begin
            state_q <= state_d;
            if (seed_req_i) begin
                seed_q     <= seed_i;
                warm_cnt_q <= '0;
            end else if (state_q == ST_LOAD) begin
                warm_cnt_q <= WARM_INIT;
            end else if (state_q == ST_WARMUP && warm_cnt_q != '0) begin
                warm_cnt_q <= warm_cnt_q - 1'b1;
            end
        end
    end

    // Grant, delivered number and round-robin pointer; pointer survives reseeds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q    <= '0;
            number_q <= '0;
            ptr_q    <= '0;
        end else begin
            gnt_q <= arb_gnt;
            if (|arb_gnt) begin
                number_q <= rng_number_i;
                ptr_q    <= arb_next_ptr;
            end
        end
    end

`ifdef RNG_ARB_STATS_EN
    logic [31:0] grant_cnt_q;

    // Saturating count of delivered numbers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '0;
        end else if (|arb_gnt && grant_cnt_q != 32'hFFFF_FFFF) begin
            grant_cnt_q <= grant_cnt_q + 32'd1;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
`else
`endif

    assign ready_o        = (state_q == ST_RUN);
    assign seed_ack_o     = (state_q == ST_LOAD);
    assign rng_loadseed_o = (state_q == ST_LOAD);
    assign rng_seed_o     = seed_q;
    assign gnt_o          = gnt_q;
    assign number_o       = number_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// tb/tb_rng_arbiter.sv - scoreboard bench for rng_arbiter (N_REQ=4, WARMUP=8; RNG_ARB_STATS_EN optional)
module tb_rng_arbiter;

    localparam logic [63:0] SEED_A = 64'h9C3CF1A59C3CF1A5;
    localparam logic [63:0] SEED_B = 64'h0123456789ABCDEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        seed_req_i = 1'b0;
    logic [63:0] seed_i = '0;
    logic        seed_ack_o;
    logic        ready_o;
    logic [3:0]  req_i = '0;
    logic [3:0]  gnt_o;
    logic [63:0] number_o;
    logic        rng_loadseed_o;
    logic [63:0] rng_seed_o;
    logic [63:0] rng_number_i;
`ifdef RNG_ARB_STATS_EN
    logic [31:0] grant_cnt_o;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_num = '0;
    logic [31:0] num_ctr = 32'd1;

    rng_arbiter #(.N_REQ(4), .WIDTH(64), .WARMUP(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .seed_req_i     (seed_req_i),
        .seed_i         (seed_i),
        .seed_ack_o     (seed_ack_o),
        .ready_o        (ready_o),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .number_o       (number_o),
        .rng_loadseed_o (rng_loadseed_o),
        .rng_seed_o     (rng_seed_o),
`ifdef RNG_ARB_STATS_EN
        .grant_cnt_o    (grant_cnt_o),
`endif
        .rng_number_i   (rng_number_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, queue the expected number if a grant is due, then score the outputs
    task automatic cyc(input logic [3:0] req, input logic sreq, input logic [63:0] sd,
                       input logic [3:0] exp_gnt);
        req_i      = req;
        seed_req_i = sreq;
        seed_i     = sd;
        if (exp_gnt != 4'b0) sb_q.push_back(rng_number_i);
        @(posedge clk);
        #1;
        num_ctr      = num_ctr + 32'd1;
        rng_number_i = {num_ctr, num_ctr ^ 32'h5A5A_C3C3};
        check("gnt", {60'b0, gnt_o}, {60'b0, exp_gnt});
        if (gnt_o != 4'b0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_grant", {60'b0, gnt_o}, 64'b0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("number", number_o, e);
                check("distinct", {63'b0, number_o != last_num}, 64'd1);
                last_num = number_o;
            end
        end
    endtask

    task automatic seed_sequence(input logic [3:0] req, input logic [63:0] sd);
        cyc(req, 1'b1, sd, 4'b0);
        check("loadseed", {63'b0, rng_loadseed_o}, 64'd1);
        check("seed_ack", {63'b0, seed_ack_o}, 64'd1);
        check("rng_seed", rng_seed_o, sd);
        check("ready_load", {63'b0, ready_o}, 64'd0);
        for (int k = 1; k <= 9; k++) begin
            cyc(req, 1'b0, 64'b0, 4'b0);
            check("ready_warm", {63'b0, ready_o}, {63'b0, k == 9});
            if (k == 1) check("ack_pulse", {63'b0, seed_ack_o | rng_loadseed_o}, 64'd0);
        end
    endtask

    initial begin
        rng_number_i = {num_ctr, num_ctr ^ 32'h5A5A_C3C3};
        #1;
        check("rst_gnt", {60'b0, gnt_o}, 64'd0);
        check("rst_number", number_o, 64'd0);
        check("rst_seed", rng_seed_o, 64'd0);
        check("rst_ready", {63'b0, ready_o}, 64'd0);
        check("rst_ack", {63'b0, seed_ack_o | rng_loadseed_o}, 64'd0);
`ifdef RNG_ARB_STATS_EN
        check("rst_cnt", {32'b0, grant_cnt_o}, 64'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Unseeded: requests are ignored
        for (int k = 0; k < 20; k++) begin
            cyc(4'b1111, 1'b0, 64'b0, 4'b0);
            check("idle_ready", {63'b0, ready_o}, 64'd0);
        end
        check("idle_number", number_o, 64'd0);

        // Seed, warm up, then rotate through all requesters
        seed_sequence(4'b1111, SEED_A);
        cyc(4'b1111, 1'b0, 64'b0, 4'b0001);
        cyc(4'b1111, 1'b0, 64'b0, 4'b0010);
        cyc(4'b1111, 1'b0, 64'b0, 4'b0100);
        cyc(4'b1111, 1'b0, 64'b0, 4'b1000);
        cyc(4'b1111, 1'b0, 64'b0, 4'b0001);

        // Sparse requests skip empty slots
        cyc(4'b0101, 1'b0, 64'b0, 4'b0100);
        cyc(4'b0101, 1'b0, 64'b0, 4'b0001);

        // No request: number holds
        cyc(4'b0000, 1'b0, 64'b0, 4'b0000);
        check("number_hold", number_o, last_num);

        // Reseed beats a pending request; pointer is kept across the reload
        seed_sequence(4'b0010, SEED_B);
        cyc(4'b0010, 1'b0, 64'b0, 4'b0010);
        cyc(4'b1011, 1'b0, 64'b0, 4'b1000);
        cyc(4'b0000, 1'b0, 64'b0, 4'b0000);
`ifdef RNG_ARB_STATS_EN
        check("cnt_before_rst", {32'b0, grant_cnt_o}, 64'd9);
`endif

        // Reset in the middle of warm-up
        cyc(4'b0000, 1'b1, SEED_A, 4'b0);
        for (int k = 0; k < 3; k++) cyc(4'b0000, 1'b0, 64'b0, 4'b0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {63'b0, ready_o}, 64'd0);
        check("mid_rst_ack", {63'b0, seed_ack_o | rng_loadseed_o}, 64'd0);
        check("mid_rst_seed", rng_seed_o, 64'd0);
        check("mid_rst_number", number_o, 64'd0);
        check("mid_rst_gnt", {60'b0, gnt_o}, 64'd0);
`ifdef RNG_ARB_STATS_EN
        check("mid_rst_cnt", {32'b0, grant_cnt_o}, 64'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        last_num = '0;
        for (int k = 0; k < 15; k++) begin
            cyc(4'b1111, 1'b0, 64'b0, 4'b0);
            check("post_rst_ready", {63'b0, ready_o}, 64'd0);
        end

        // Fresh seed after reset: pointer starts from requester 0 again
        seed_sequence(4'b1111, SEED_B);
        cyc(4'b1111, 1'b0, 64'b0, 4'b0001);
        cyc(4'b1111, 1'b0, 64'b0, 4'b0010);
        cyc(4'b1111, 1'b0, 64'b0, 4'b0100);
        cyc(4'b1111, 1'b0, 64'b0, 4'b1000);
        cyc(4'b1110, 1'b0, 64'b0, 4'b0010);
        cyc(4'b0000, 1'b0, 64'b0, 4'b0000);
`ifdef RNG_ARB_STATS_EN
        check("cnt_after", {32'b0, grant_cnt_o}, 64'd5);
`endif

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
